// File: rtl/decode_stage_if.sv
// Decode-stage signal bundle: instruction/write-back/debug inputs
// and the ID/EX register outputs, with driver and stage views.
interface decode_stage_if #(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int NB_INSTRUCTIONS   = 32,
  parameter int NB_ALU_OP         = 6
);
  logic [NB_INSTRUCTIONS-1:0]   i_instruction;
  logic                         i_enable;
  logic                         i_flush;
  logic                         i_wb_write;
  logic [NB_ADDR_REGISTERS-1:0] i_wb_addr;
  logic [NB_DATA-1:0]           i_wb_data;
  logic [NB_ADDR_REGISTERS-1:0] i_dbg_addr;
  logic [NB_DATA-1:0]           o_dbg_data;
  logic                         o_stall;
  logic                         o_valid;
  logic [NB_DATA-1:0]           o_bus_a;
  logic [NB_DATA-1:0]           o_bus_b;
  logic [NB_DATA-1:0]           o_ext_literal;
  logic [NB_ADDR_REGISTERS-1:0] o_rs;
  logic [NB_ADDR_REGISTERS-1:0] o_rt;
  logic [NB_ADDR_REGISTERS-1:0] o_dest;
  logic [NB_ALU_OP-1:0]         o_alu_op;
  logic                         o_alu_src;
  logic                         o_mem_read;
  logic                         o_mem_write;
  logic [1:0]                   o_mem_width;
  logic                         o_mem_unsigned;
  logic                         o_reg_write;
  logic                         o_mem_to_reg;

  modport master (
    output i_instruction, i_enable, i_flush,
    output i_wb_write, i_wb_addr, i_wb_data, i_dbg_addr,
    input  o_dbg_data, o_stall, o_valid, o_bus_a, o_bus_b,
    input  o_ext_literal, o_rs, o_rt, o_dest, o_alu_op,
    input  o_alu_src, o_mem_read, o_mem_write, o_mem_width,
    input  o_mem_unsigned, o_reg_write, o_mem_to_reg
  );

  modport slave (
    input  i_instruction, i_enable, i_flush,
    input  i_wb_write, i_wb_addr, i_wb_data, i_dbg_addr,
    output o_dbg_data, o_stall, o_valid, o_bus_a, o_bus_b,
    output o_ext_literal, o_rs, o_rt, o_dest, o_alu_op,
    output o_alu_src, o_mem_read, o_mem_write, o_mem_width,
    output o_mem_unsigned, o_reg_write, o_mem_to_reg
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register file with write-through bypass,
// control decode, load-use hazard detect and the ID/EX register.
module decode_stage #(
  parameter int NB_DATA           = 32,
  parameter int N_REGISTERS       = 32,
  parameter int NB_ADDR_REGISTERS = 5,
  parameter int NB_INSTRUCTIONS   = 32,
  parameter int NB_ALU_OP         = 6
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NB_INSTRUCTIONS-1:0]   i_instruction,
  input  logic                         i_enable,
  input  logic                         i_flush,
  input  logic                         i_wb_write,
  input  logic [NB_ADDR_REGISTERS-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0]           i_wb_data,
  input  logic [NB_ADDR_REGISTERS-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]           o_dbg_data,
  output logic                         o_stall,
  output logic                         o_valid,
  output logic [NB_DATA-1:0]           o_bus_a,
  output logic [NB_DATA-1:0]           o_bus_b,
  output logic [NB_DATA-1:0]           o_ext_literal,
  output logic [NB_ADDR_REGISTERS-1:0] o_rs,
  output logic [NB_ADDR_REGISTERS-1:0] o_rt,
  output logic [NB_ADDR_REGISTERS-1:0] o_dest,
  output logic [NB_ALU_OP-1:0]         o_alu_op,
  output logic                         o_alu_src,
  output logic                         o_mem_read,
  output logic                         o_mem_write,
  output logic [1:0]                   o_mem_width,
  output logic                         o_mem_unsigned,
  output logic                         o_reg_write,
  output logic                         o_mem_to_reg
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int NA = NB_ADDR_REGISTERS;
  localparam int NX = NB_DATA - 16;

  typedef struct packed {
    logic                 valid;
    logic [NB_DATA-1:0]   bus_a;
    logic [NB_DATA-1:0]   bus_b;
    logic [NB_DATA-1:0]   lit;
    logic [NA-1:0]        rs;
    logic [NA-1:0]        rt;
    logic [NA-1:0]        dest;
    logic [NB_ALU_OP-1:0] alu_op;
    logic                 alu_src;
    logic                 mem_read;
    logic                 mem_write;
    logic [1:0]           mem_width;
    logic                 mem_unsigned;
    logic                 reg_write;
    logic                 mem_to_reg;
  } id_ex_t;

  logic [NB_DATA-1:0] rf_q [N_REGISTERS];

  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [NA-1:0] rs, rt, rd;
  logic unused_shamt;

  assign opcode = i_instruction[31:26];
  assign rs     = i_instruction[21 +: NA];
  assign rt     = i_instruction[16 +: NA];
  assign rd     = i_instruction[11 +: NA];
  assign func   = i_instruction[5:0];
  assign imm    = i_instruction[15:0];
  assign unused_shamt = ^i_instruction[10:6];

  logic is_r, is_j, is_jal, is_lui, is_load, is_store;
  logic is_branch, is_imm, is_logic_imm, rs_used, rt_used;

  assign is_r      = opcode == OP_R;
  assign is_j      = opcode == OP_J;
  assign is_jal    = opcode == OP_JAL;
  assign is_lui    = opcode == OP_LUI;
  assign is_load   = opcode[5:3] == 3'b100;
  assign is_store  = opcode[5:3] == 3'b101;
  assign is_branch = opcode[5:1] == 5'b00010;
  assign is_logic_imm = (opcode == OP_ANDI) ||
                        (opcode == OP_ORI)  ||
                        (opcode == OP_XORI);
  assign is_imm = is_logic_imm || is_lui ||
                  (opcode == OP_ADDI) || (opcode == OP_SLTI);
  assign rs_used = !(is_j || is_jal || is_lui);
  assign rt_used = is_r || is_store || is_branch;

  // Write-through: a same-cycle write-back wins over the stored value
  logic [NB_DATA-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = rf_q[rs];
    rd_b = rf_q[rt];
    if (i_wb_write && i_wb_addr == rs)
      rd_a = i_wb_data;
    if (i_wb_write && i_wb_addr == rt)
      rd_b = i_wb_data;
    if (rs == '0)
      rd_a = '0;
    if (rt == '0)
      rd_b = '0;
  end

  assign o_dbg_data = rf_q[i_dbg_addr];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_REGISTERS; i++)
        rf_q[i] <= '0;
    end else if (i_wb_write && i_wb_addr != '0) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  logic [5:0] alu_op;

  always_comb begin
    alu_op = 6'b000000;
    unique case (1'b1)
      is_r:                 alu_op = func;
      is_load || is_store:  alu_op = 6'b100001;
      is_branch:            alu_op = 6'b100011;
      opcode == OP_ADDI:    alu_op = 6'b100001;
      opcode == OP_ANDI:    alu_op = 6'b100100;
      opcode == OP_ORI:     alu_op = 6'b100101;
      opcode == OP_XORI:    alu_op = 6'b100110;
      opcode == OP_SLTI:    alu_op = 6'b101010;
      is_lui:               alu_op = 6'b001111;
      default:              alu_op = 6'b000000;
    endcase
  end

  id_ex_t dec, idex_q, idex_d;

  always_comb begin
    dec              = '0;
    dec.valid        = 1'b1;
    dec.bus_a        = rd_a;
    dec.bus_b        = rd_b;
    dec.rs           = rs;
    dec.rt           = rt;
    dec.alu_op       = NB_ALU_OP'(alu_op);
    dec.alu_src      = is_imm || is_load || is_store;
    dec.mem_read     = is_load;
    dec.mem_write    = is_store;
    dec.mem_width    = opcode[1:0];
    dec.mem_unsigned = opcode[2];
    dec.mem_to_reg   = is_load;
    dec.reg_write    = (is_r && func != FN_JR) || is_imm ||
                       is_load || is_jal;
    unique case (1'b1)
      is_logic_imm: dec.lit = {{NX{1'b0}}, imm};
      is_lui:       dec.lit = {imm, {NX{1'b0}}};
      default:      dec.lit = {{NX{imm[15]}}, imm};
    endcase
    unique case (1'b1)
      is_r:    dec.dest = rd;
      is_jal:  dec.dest = NA'(31);
      default: dec.dest = rt;
    endcase
  end

  // Only a load already in ID/EX can hazard the instruction in decode
  assign o_stall = idex_q.valid && idex_q.mem_read &&
                   idex_q.dest != '0 &&
                   ((rs_used && idex_q.dest == rs) ||
                    (rt_used && idex_q.dest == rt));

  always_comb begin
    idex_d = idex_q;
    if (i_enable) begin
      idex_d = dec;
      if (i_flush || o_stall) begin
        idex_d.valid      = 1'b0;
        idex_d.reg_write  = 1'b0;
        idex_d.mem_read   = 1'b0;
        idex_d.mem_write  = 1'b0;
        idex_d.mem_to_reg = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      idex_q <= '0;
    else
      idex_q <= idex_d;
  end

  assign o_valid        = idex_q.valid;
  assign o_bus_a        = idex_q.bus_a;
  assign o_bus_b        = idex_q.bus_b;
  assign o_ext_literal  = idex_q.lit;
  assign o_rs           = idex_q.rs;
  assign o_rt           = idex_q.rt;
  assign o_dest         = idex_q.dest;
  assign o_alu_op       = idex_q.alu_op;
  assign o_alu_src      = idex_q.alu_src;
  assign o_mem_read     = idex_q.mem_read;
  assign o_mem_write    = idex_q.mem_write;
  assign o_mem_width    = idex_q.mem_width;
  assign o_mem_unsigned = idex_q.mem_unsigned;
  assign o_reg_write    = idex_q.reg_write;
  assign o_mem_to_reg   = idex_q.mem_to_reg;

endmodule
